parity_sched: RTL
=================

PARITY_SCHED -- requirements
Module: parity_sched

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, meaning per-requester error counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester request; bit i belongs to requester i.
REQ-006 SHALL have port req_data  input  2*WIDTH  packed words; requester i uses bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port req_chk  input  2  per-requester check enable.
REQ-008 SHALL have port req_exp  input  2  per-requester expected parity bit.
REQ-009 SHALL have port gnt  output  2  one-hot grant, registered.
REQ-010 SHALL have port resp_valid  output  1  result available.
REQ-011 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-012 SHALL have port resp_id  output  1  requester index of the result.
REQ-013 SHALL have port resp_parity  output  1  computed parity of the captured word.
REQ-014 SHALL have port resp_err  output  1  check mismatch flag.
REQ-015 SHALL have port clr_cnt  input  1  synchronous clear of both error counters.
REQ-016 SHALL have ports err_cnt0 and err_cnt1  output  CNT_W each  error counts of requesters 0 and 1.

Function
REQ-017 Parity SHALL be the XOR of all captured data bits (1 when the number of ones is odd).
REQ-018 FSM SHALL have states IDLE, GRANT, CALC, RESP; one transaction occupies at least 4 cycles.
REQ-019 IDLE: if req != 0, go to GRANT and set gnt one-hot to the chosen requester; else stay, gnt = 0.
REQ-020 Arbitration SHALL be round-robin: on simultaneous req, the requester not served last wins; after reset requester 0 wins.
REQ-021 GRANT (gnt asserted for exactly this one cycle): capture req_data, req_chk and req_exp of the granted requester; go to CALC.
REQ-022 A requester SHALL hold req, data, chk and exp stable until it sees gnt; a req drop during GRANT SHALL NOT abort the transaction.
REQ-023 CALC: register resp_parity, resp_id and resp_err = chk AND (parity != exp); go to RESP.
REQ-024 RESP: resp_valid = 1 with outputs stable until resp_ready = 1; on that cycle go to IDLE and update the last-served pointer.
REQ-025 resp_valid SHALL be 0 in IDLE, GRANT and CALC; resp_ready outside RESP SHALL be ignored.
REQ-026 On the RESP handshake with resp_err = 1, err_cnt[resp_id] SHALL increment by 1, saturating at 2^CNT_W-1.
REQ-027 clr_cnt SHALL zero both counters on the next edge and take priority over a same-cycle increment.
REQ-028 req held continuously by one requester only SHALL be served back-to-back, one transaction per 4 cycles minimum.

Reset
REQ-029 rst_n low SHALL immediately force state IDLE, gnt = 0, resp_valid = 0, resp_id = 0, resp_parity = 0, resp_err = 0, both counters = 0, last-served pointer = 1.
REQ-030 Reset mid-transaction SHALL discard the transaction with no counter update; the first request after reset SHALL be granted as in REQ-019.

Structure
REQ-031 A shared package SHALL hold the state enumeration and requester index constants (REQ0 = 0, REQ1 = 1).
REQ-032 Parity computation SHALL instantiate the team's existing parameterised parity sub-module "parity" (WIDTH) on the captured word.

Verification
REQ-033 req=01, data0=8'b10101011, chk0=0, resp_ready=1 -> gnt=01 one cycle after req, resp_valid 3 cycles after req, resp_id=0, resp_parity=1, resp_err=0.
REQ-034 req=11 held, resp_ready=1 -> grant sequence 01,10,01,10; resp_id alternates 0,1,0,1.
REQ-035 requester 1, data=8'h00, chk=1, exp=1 -> resp_err=1, err_cnt1 = 1, err_cnt0 = 0; same with exp=0 -> resp_err=0, no increment.
REQ-036 resp_ready=0 for 5 cycles in RESP -> resp_valid and outputs stable, no new gnt; counter updates only on the accepting cycle.
REQ-037 CNT_W=2, 5 mismatches on requester 0 -> err_cnt0 saturates at 3; clr_cnt during a mismatch handshake -> err_cnt0 = 0.
REQ-038 rst_n low during CALC -> resp_valid, gnt, counters 0 immediately; next req=10 -> gnt=10.

Source files
------------

// File: rtl/parity_sched_pkg.sv
// Shared types for the parity scheduler: FSM states, requester indices and
// the round-robin pick helper.
package parity_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        CALC  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    // On a tie, the requester that was not served last wins.
    function automatic logic rr_pick(input logic [1:0] req, input logic last);
        if (req == 2'b11)
            return ~last;
        return req[1] ? REQ1 : REQ0;
    endfunction

endpackage

// File: rtl/parity.sv
// Word parity: XOR reduction of data, combinational, zero latency.
// No flow control; output follows input.
module parity #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             par
);

    assign par = ^data;

endmodule

// File: rtl/parity_sched.sv
// Two-requester round-robin parity checker: IDLE->GRANT->CALC->RESP, result valid 3 cycles after req.
// Result held in RESP until resp_ready; no new grant is issued while a result is pending.
module parity_sched
    import parity_sched_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req,
    input  logic [2*WIDTH-1:0] req_data,
    input  logic [1:0]         req_chk,
    input  logic [1:0]         req_exp,
    output logic [1:0]         gnt,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic               resp_id,
    output logic               resp_parity,
    output logic               resp_err,
    input  logic               clr_cnt,
    output logic [CNT_W-1:0]   err_cnt0,
    output logic [CNT_W-1:0]   err_cnt1
);

    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state, state_nxt;

    logic             last;
    logic             sel;
    logic             sel_q;
    logic [WIDTH-1:0] cap_data;
    logic             cap_chk;
    logic             cap_exp;
    logic             par;
    logic             accept;

    assign sel        = rr_pick(req, last);
    assign resp_valid = (state == RESP);
    assign accept     = (state == RESP) && resp_ready;

    parity #(.WIDTH(WIDTH)) u_parity (
        .data (cap_data),
        .par  (par)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req != 2'b00) state_nxt = GRANT;
            GRANT:   state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gnt         <= 2'b00;
            sel_q       <= REQ0;
            last        <= REQ1;
            cap_data    <= '0;
            cap_chk     <= 1'b0;
            cap_exp     <= 1'b0;
            resp_id     <= REQ0;
            resp_parity <= 1'b0;
            resp_err    <= 1'b0;
        end else begin
            state <= state_nxt;
            // gnt is high only for the GRANT cycle that follows arbitration.
            if (state == IDLE && req != 2'b00) begin
                gnt   <= sel ? 2'b10 : 2'b01;
                sel_q <= sel;
            end else begin
                gnt <= 2'b00;
            end
            if (state == GRANT) begin
                cap_data <= sel_q ? req_data[2*WIDTH-1 -: WIDTH] : req_data[WIDTH-1:0];
                cap_chk  <= req_chk[sel_q];
                cap_exp  <= req_exp[sel_q];
            end
            if (state == CALC) begin
                resp_parity <= par;
                resp_id     <= sel_q;
                resp_err    <= cap_chk & (par ^ cap_exp);
            end
            if (accept)
                last <= resp_id;
        end
    end

    // Clear wins over an increment landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (clr_cnt) begin
            err_cnt0 <= '0;
            err_cnt1 <= '0;
        end else if (accept && resp_err) begin
            if (resp_id == REQ1) begin
                if (err_cnt1 != CNT_MAX) err_cnt1 <= err_cnt1 + CNT_ONE;
            end else begin
                if (err_cnt0 != CNT_MAX) err_cnt0 <= err_cnt0 + CNT_ONE;
            end
        end
    end

endmodule
